cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 183 ++++++++++++++++++
 tb/tb_cache_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate cache controller (64 sets x 1 word/way).
// Optional build macro CACHE_STATS_EN adds read hit/miss counters on hit_count and miss_count.
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t state_q, state_d;

  logic [63:0] valid_q [2];
  logic [63:0] lru_q;
  logic [9:0]  tag_q   [2][64];
  logic [31:0] data_q  [2][64];

  logic [5:0]  idx;
  logic [9:0]  tag;
  logic        hit0, hit1, hit;
  logic        hit_way, victim_way;
  logic [31:0] hit_data;
  logic        fill_en, wupd_en, lru_en, lru_d;
  logic        hit_inc, miss_inc;
  logic        unused_addr_bits;

  assign idx = address[7:2];
  assign tag = address[17:8];
  assign unused_addr_bits = ^{address[31:18], address[1:0]};

  assign sram_address = address;
  assign sram_wdata   = write_data;

  assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;
  assign hit_data = data_q[hit_way][idx];

  // Fill an empty way first (way0 before way1); otherwise replace the least recent one.
  always_comb begin
    if (!valid_q[0][idx])      victim_way = 1'b0;
    else if (!valid_q[1][idx]) victim_way = 1'b1;
    else                       victim_way = lru_q[idx];
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b1;
    read_data  = '0;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    fill_en    = 1'b0;
    wupd_en    = 1'b0;
    lru_en     = 1'b0;
    lru_d      = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    if (!rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            sram_wr_en = 1'b1;
            ready      = 1'b0;
            state_d    = WR_THRU;
          end else if (rd_en) begin
            if (hit) begin
              read_data = hit_data;
              lru_en    = 1'b1;
              lru_d     = ~hit_way;
              hit_inc   = 1'b1;
            end else begin
              sram_rd_en = 1'b1;
              ready      = 1'b0;
              state_d    = RD_MISS;
            end
          end
        end
        RD_MISS: begin
          // A withdrawn request abandons the miss without touching the arrays.
          if (rd_en && !wr_en) begin
            sram_rd_en = 1'b1;
            if (sram_ready) begin
              read_data = sram_rdata;
              fill_en   = 1'b1;
              lru_en    = 1'b1;
              lru_d     = ~victim_way;
              miss_inc  = 1'b1;
              state_d   = IDLE;
            end else begin
              ready = 1'b0;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WR_THRU: begin
          if (wr_en) begin
            sram_wr_en = 1'b1;
            if (sram_ready) begin
              if (hit) begin
                wupd_en = 1'b1;
                lru_en  = 1'b1;
                lru_d   = ~hit_way;
              end
              state_d = IDLE;
            end else begin
              ready = 1'b0;
            end
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) valid_q[victim_way][idx] <= 1'b1;
      if (lru_en)  lru_q[idx] <= lru_d;
    end
  end

  // Tag and data storage carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[victim_way][idx]  <= tag;
      data_q[victim_way][idx] <= sram_rdata;
    end else if (wupd_en) begin
      data_q[hit_way][idx] <= write_data;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q + {31'd0, hit_inc};
    miss_count_d = miss_count_q + {31'd0, miss_inc};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a fixed-latency SRAM model and a result scoreboard.
module tb_cache_controller;
  localparam int LAT = 6;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        sram_ready;
  logic        sram_req;
  int          lat_cnt = 0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [31:0] exp_q [$];

  cache_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // SRAM answers in the LAT-th cycle of an uninterrupted request.
  assign sram_req   = sram_rd_en | sram_wr_en;
  assign sram_ready = sram_req && (lat_cnt == LAT - 1);
  always @(posedge clk) begin
    if (sram_req && !sram_ready) lat_cnt <= lat_cnt + 1;
    else                         lat_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    assert (got === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, got, exp_v);
    end
  endtask

  always @(negedge clk) chk("sram_excl", {31'd0, sram_rd_en & sram_wr_en}, 32'd0);

  task automatic idle_chk(input string name);
    @(negedge clk);
    chk({name, "_ready"}, {31'd0, ready}, 32'd1);
    chk({name, "_rdata"}, read_data, 32'd0);
    chk({name, "_srd"}, {31'd0, sram_rd_en}, 32'd0);
    chk({name, "_swr"}, {31'd0, sram_wr_en}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] sdata,
                         input logic [31:0] exp_v, input bit exp_hit);
    int cyc;
    address = a; rd_en = 1'b1; wr_en = 1'b0; sram_rdata = sdata;
    exp_q.push_back(exp_v);
    cyc = 0;
    @(negedge clk);
    while (!ready && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_lat"}, 32'(cyc), 32'(exp_hit ? 0 : LAT - 1));
    chk({name, "_srd"}, {31'd0, sram_rd_en}, {31'd0, !exp_hit});
    chk({name, "_data"}, read_data, exp_q.pop_front());
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d,
                          input bit with_rd);
    int cyc;
    int bad;
    address = a; write_data = d; wr_en = 1'b1; rd_en = with_rd;
    exp_q.push_back(d);
    cyc = 0; bad = 0;
    @(negedge clk);
    while (!ready && cyc < TMO) begin
      if (!sram_wr_en || sram_rd_en) bad++;
      @(negedge clk);
      cyc++;
    end
    chk({name, "_lat"}, 32'(cyc), 32'(LAT - 1));
    chk({name, "_held"}, 32'(bad), 32'd0);
    chk({name, "_swr"}, {sram_rd_en, sram_wr_en}, 32'd1);
    chk({name, "_wdata"}, sram_wdata, exp_q.pop_front());
    chk({name, "_addr"}, sram_address, a);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd_en = 1'b1; address = 32'h104;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_srd", {31'd0, sram_rd_en}, 32'd0);
    chk("rst_swr", {31'd0, sram_wr_en}, 32'd0);
    @(posedge clk); #1;
    rd_en = 1'b0; rst = 1'b1;
    idle_chk("idle0");

    do_read("r030_miss", 32'h104, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    do_read("r030_hit", 32'h104, 32'h0, 32'hDEADBEEF, 1'b1);

    do_read("r031_fill204", 32'h204, 32'hA0A00204, 32'hA0A00204, 1'b0);
    do_read("r031_hit104", 32'h104, 32'h0, 32'hDEADBEEF, 1'b1);
    do_read("r031_fill304", 32'h304, 32'hC0C00304, 32'hC0C00304, 1'b0);
    do_read("r031_hit104b", 32'h104, 32'h0, 32'hDEADBEEF, 1'b1);
    do_read("r031_miss204", 32'h204, 32'hA0A00204, 32'hA0A00204, 1'b0);

    do_write("r032_wr104", 32'h104, 32'h12345678, 1'b0);
    do_read("r032_hit104", 32'h104, 32'h0, 32'h12345678, 1'b1);
    do_write("r032_wr408", 32'h408, 32'h0BADF00D, 1'b0);
    do_read("r032_miss408", 32'h408, 32'h5EED0408, 32'h5EED0408, 1'b0);

    do_write("r033_rdwr", 32'h104, 32'hCAFEF00D, 1'b1);
    do_read("r033_hit104", 32'h104, 32'h0, 32'hCAFEF00D, 1'b1);

    // Withdrawn read: no fill, so the same address misses again.
    address = 32'h604; rd_en = 1'b1; sram_rdata = 32'h0;
    @(negedge clk);
    chk("abort_srd", {31'd0, sram_rd_en}, 32'd1);
    chk("abort_busy", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_srd_off", {31'd0, sram_rd_en}, 32'd0);
    @(posedge clk); #1;
    do_read("abort_refetch", 32'h604, 32'h60606060, 32'h60606060, 1'b0);

    // Reset in the middle of a miss.
    address = 32'h508; rd_en = 1'b1;
    @(negedge clk);
    chk("rmid_srd", {31'd0, sram_rd_en}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_ready", {31'd0, ready}, 32'd1);
    chk("rmid_srd_off", {31'd0, sram_rd_en}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; rd_en = 1'b0;
    idle_chk("rmid_idle");
    do_read("r033_miss104", 32'h104, 32'h77777777, 32'h77777777, 1'b0);

`ifdef CACHE_STATS_EN
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("stat_hit0", hit_count, 32'd0);
    chk("stat_miss0", miss_count, 32'd0);
    do_read("st_m1", 32'h104, 32'h11111111, 32'h11111111, 1'b0);
    do_read("st_h1", 32'h104, 32'h0, 32'h11111111, 1'b1);
    do_read("st_h2", 32'h104, 32'h0, 32'h11111111, 1'b1);
    do_read("st_h3", 32'h104, 32'h0, 32'h11111111, 1'b1);
    do_read("st_m2", 32'h204, 32'h22222222, 32'h22222222, 1'b0);
    chk("stat_hit3", hit_count, 32'd3);
    chk("stat_miss2", miss_count, 32'd2);
    dut.hit_count_q = 32'hFFFFFFFF;
    do_read("st_wrap", 32'h104, 32'h0, 32'h11111111, 1'b1);
    chk("stat_wrap", hit_count, 32'd0);
`endif

    idle_chk("idle_end");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
